alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. the execute stage (requester 0) and the branch/address unit (requester 1).
- Each requester uses a valid/ready request channel; one shared response channel carries the result.
- Arbitration is round-robin. Operands are registered before the ALU and the result is registered after it, so the ALU sits between two flop stages.
- The block drives the ALU operand and control inputs and samples the ALU result and zero outputs.

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the shared-ALU arbiter: two valid/ready request
// channels feeding the arbiter and one valid/ready response channel back out.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  // Requester 0 channel
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [OP_WIDTH-1:0]   req0_op;

  // Requester 1 channel
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [OP_WIDTH-1:0]   req1_op;

  // Shared response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;

  // Requesters and response consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered in front of the ALU and the result behind it, so an
// operation takes IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result).
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  // Requester that owned the last completed response; starts at 1 so
  // requester 0 wins the first tie after reset.
  logic                  last_served_reg;

  // Operand stage in front of the ALU
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [OP_WIDTH-1:0]   op_reg;
  logic                  id_reg;

  // Result stage behind the ALU
  logic [DATA_WIDTH-1:0] rsp_result_reg;
  logic                  rsp_zero_reg;
  logic                  rsp_id_reg;

  // Requester channels gathered into vectors so grant/ready logic is uniform
  logic [1:0]            valid_vec;
  logic [1:0]            ready_vec;
  logic [DATA_WIDTH-1:0] a_vec  [2];
  logic [DATA_WIDTH-1:0] b_vec  [2];
  logic [OP_WIDTH-1:0]   op_vec [2];

  logic                  grant_id;
  logic                  handshake;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};
  assign a_vec[0]  = bus.req0_a;
  assign a_vec[1]  = bus.req1_a;
  assign b_vec[0]  = bus.req0_b;
  assign b_vec[1]  = bus.req1_b;
  assign op_vec[0] = bus.req0_op;
  assign op_vec[1] = bus.req1_op;

  // Round-robin pick: a lone requester always wins, the pointer only breaks ties
  always_comb begin
    grant_id = 1'b0;
    if (valid_vec == 2'b11) begin
      grant_id = ~last_served_reg;
    end else if (valid_vec == 2'b10) begin
      grant_id = 1'b1;
    end
  end

  // Ready is only offered in IDLE, to the granted requester, while it is valid
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    localparam logic REQ_ID = 1'(gi);
    assign ready_vec[gi] = (state_reg == IDLE) && valid_vec[gi] && (grant_id == REQ_ID);
  end

  assign handshake      = |ready_vec;
  assign bus.req0_ready = ready_vec[0];
  assign bus.req1_ready = ready_vec[1];

  // Next-state logic; rsp_ready only matters while a response is presented
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the granted requester's operands on the request handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      id_reg <= 1'b0;
    end else if (handshake) begin
      a_reg  <= a_vec[grant_id];
      b_reg  <= b_vec[grant_id];
      op_reg <= op_vec[grant_id];
      id_reg <= grant_id;
    end
  end

  // Sample the ALU at the end of EXEC; held untouched through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_id_reg     <= 1'b0;
    end else if (state_reg == EXEC) begin
      rsp_result_reg <= alu_result;
      rsp_zero_reg   <= alu_zero;
      rsp_id_reg     <= id_reg;
    end
  end

  // Advance the round-robin pointer only when a response is actually consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served_reg <= 1'b1;
    end else if ((state_reg == RESP) && bus.rsp_ready) begin
      last_served_reg <= rsp_id_reg;
    end
  end

  // ALU is fed straight from the operand stage, so its inputs only move on accept
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_control = op_reg;

  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_zero   = rsp_zero_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drives both requesters and the response
// consumer, models the external ALU, and checks each step against
// hand-computed values.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [OW-1:0] alu_control;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          busy;

  int vectors;
  int miscompares;

  alu_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  // External ALU: 0000 add, 0001 sub, anything else bitwise AND
  assign alu_result = (alu_control == 4'b0000) ? (alu_a + alu_b) :
                      (alu_control == 4'b0001) ? (alu_a - alu_b) : (alu_a & alu_b);
  assign alu_zero   = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_ready0",    32'(bus.req0_ready), 32'd0);
    chk("rst_ready1",    32'(bus.req1_ready), 32'd0);
    chk("rst_result",    bus.rsp_result,      32'd0);
    chk("rst_alu_a",     alu_a,               32'd0);
    #3 rst_n = 1'b1;
    tick();

    // ---- single req0: 5 + 3 ----
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_op = 4'b0000;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("t1_ready0",  32'(bus.req0_ready), 32'd1);
    chk("t1_ready1",  32'(bus.req1_ready), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_exec_ready0", 32'(bus.req0_ready), 32'd0);
    chk("t1_exec_busy",   32'(busy), 32'd1);
    chk("t1_exec_rspv",   32'(bus.rsp_valid), 32'd0);
    chk("t1_alu_a",       alu_a, 32'd5);
    chk("t1_alu_b",       alu_b, 32'd3);
    chk("t1_alu_ctl",     32'(alu_control), 32'd0);
    tick();
    chk("t1_rspv",   32'(bus.rsp_valid), 32'd1);
    chk("t1_result", bus.rsp_result, 32'd8);
    chk("t1_zero",   32'(bus.rsp_zero), 32'd0);
    chk("t1_id",     32'(bus.rsp_id), 32'd0);
    chk("t1_busy",   32'(busy), 32'd1);
    tick();
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_rspv", 32'(bus.rsp_valid), 32'd0);

    // ---- single req1: 7 - 7 (rsp_ready held high through EXEC, ignored) ----
    bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_op = 4'b0001;
    #1;
    chk("t2_ready1", 32'(bus.req1_ready), 32'd1);
    chk("t2_ready0", 32'(bus.req0_ready), 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("t2_rspv",   32'(bus.rsp_valid), 32'd1);
    chk("t2_result", bus.rsp_result, 32'd0);
    chk("t2_zero",   32'(bus.rsp_zero), 32'd1);
    chk("t2_id",     32'(bus.rsp_id), 32'd1);
    tick();

    // ---- continuous dual requests: alternate 0,1,0,1 ----
    bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd1; bus.req0_op = 4'b0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd20; bus.req1_b = 32'd4; bus.req1_op = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_op%0d_ready0", k), 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_op%0d_ready1", k), 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("t3_op%0d_exec_rdy", k), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      tick();
      chk($sformatf("t3_op%0d_id", k),     32'(bus.rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t3_op%0d_result", k), bus.rsp_result, (k % 2 == 0) ? 32'd11 : 32'd16);
      tick();
    end

    // ---- backpressure: hold RESP for 5 cycles with req0 still asking ----
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    #1;
    chk("t4_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_hold%0d_rspv", k),   32'(bus.rsp_valid), 32'd1);
      chk($sformatf("t4_hold%0d_result", k), bus.rsp_result, 32'd11);
      chk($sformatf("t4_hold%0d_id", k),     32'(bus.rsp_id), 32'd0);
      chk($sformatf("t4_hold%0d_ready0", k), 32'(bus.req0_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1; bus.req0_op = 4'b0000;
    #1;
    chk("t4_release_rspv", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("t4_back_idle",   32'(busy), 32'd0);
    chk("t4_next_ready0", 32'(bus.req0_ready), 32'd1);

    // ---- overflow FFFFFFFF + 1, plus a req1 that drops before grant ----
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    chk("t5_busy_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    chk("t5_result", bus.rsp_result, 32'd0);
    chk("t5_zero",   32'(bus.rsp_zero), 32'd1);
    tick();
    tick();
    chk("t5_withdrawn_idle", 32'(busy), 32'd0);

    // ---- reset during EXEC (pointer currently favours requester 1) ----
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_op = 4'b0000;
    tick();
    bus.req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_exec_rst_busy",  32'(busy), 32'd0);
    chk("t6_exec_rst_alu_a", alu_a, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_exec_rst_rspv", 32'(bus.rsp_valid), 32'd0);

    // ---- reset during RESP ----
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd40; bus.req0_b = 32'd2; bus.req0_op = 4'b0000;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("t6_resp_rspv",   32'(bus.rsp_valid), 32'd1);
    chk("t6_resp_result", bus.rsp_result, 32'd42);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_resp_rst_rspv",   32'(bus.rsp_valid), 32'd0);
    chk("t6_resp_rst_result", bus.rsp_result, 32'd0);
    chk("t6_resp_rst_busy",   32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // ---- first tie after reset goes to requester 0 ----
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("t6_tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t6_tie_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
